// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the divider check multiplier.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/div_check_mul_dp.sv
// Shift-add datapath: accumulator, shifted multiplicand and multiplier.
// load preloads the operands; step performs one add-shift iteration.
module div_check_mul_dp #(
    parameter int WIDTH = div_pkg::DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     quotient,
    input  logic [WIDTH-1:0]     divisor,
    input  logic [WIDTH-1:0]     residue,
    output logic [2*WIDTH-1:0]   acc
);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    // Preload on accept, otherwise conditionally add and shift once per step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= {{WIDTH{1'b0}}, residue};
            mcand  <= {{WIDTH{1'b0}}, quotient};
            mplier <= divisor;
        end else if (step) begin
            // Worst case sum is 2^(2W) - 2^W, so no carry-out is needed.
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/div_check_mul.sv
// Sequential multiplier rebuilding dividend = quotient * divisor + residue.
// Optional feature macro: DIV_CHECK_MUL_CHECK_EN adds an operand sanity flag
// (err) that marks triples which cannot be a legal division result.
module div_check_mul
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     quotient,
    input  logic [WIDTH-1:0]     divisor,
    input  logic [WIDTH-1:0]     residue,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 hi_nonzero,
    output logic                 err
);

    localparam int CNT_W = $clog2(WIDTH);

    mul_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               load, step;
    logic [2*WIDTH-1:0] acc;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and datapath enables; BUSY always runs the full WIDTH steps.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Step counter; wraps back to zero on the final BUSY step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (load) cnt <= '0;
        else if (step) cnt <= cnt + 1'b1;
    end

    div_check_mul_dp #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .quotient (quotient),
        .divisor  (divisor),
        .residue  (residue),
        .acc      (acc)
    );

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign product    = acc;
    assign hi_nonzero = |acc[2*WIDTH-1:WIDTH];

`ifdef DIV_CHECK_MUL_CHECK_EN
    logic err_q;

    // Flag triples that are not a legal division result; cleared on hand-off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               err_q <= 1'b0;
        else if (load)                         err_q <= (divisor == '0) || (residue >= divisor);
        else if (state == DONE && out_ready)   err_q <= 1'b0;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_div_check_mul.sv
// Randomized self-checking bench for div_check_mul against an arithmetic model.
module tb_div_check_mul;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   quotient = '0;
    logic [W-1:0]   divisor = '0;
    logic [W-1:0]   residue = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] product;
    logic           hi_nonzero;
    logic           err;

    int n_total = 0;
    int n_pass  = 0;
    time t_acc  = 0;

    always #5 clk = ~clk;

    div_check_mul #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .quotient   (quotient),
        .divisor    (divisor),
        .residue    (residue),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .product    (product),
        .hi_nonzero (hi_nonzero),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else             n_pass++;
    endtask

    function automatic logic [63:0] model_prod(input logic [31:0] q, d, r);
        longint unsigned p;
        p = longint'(q) * longint'(d) + longint'(r);
        return p;
    endfunction

    function automatic logic model_err(input logic [31:0] d, r);
`ifdef DIV_CHECK_MUL_CHECK_EN
        return (d == 0) || (r >= d);
`else
        return 1'b0;
`endif
    endfunction

    // One full transaction, starting and ending at a falling edge.
    // hold = cycles of out_ready low in DONE (0 = out_ready high from accept).
    task automatic run_op(input logic [31:0] q, d, r, input int hold);
        int n;
        bit ready_ok, stable_ok;
        logic [63:0] exp_p;
        exp_p = model_prod(q, d, r);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        quotient  = q;
        divisor   = d;
        residue   = r;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        t_acc = $time;
        #1;
        in_valid = 1'b0;
        quotient = $urandom;
        divisor  = $urandom;
        residue  = $urandom;
        n = 0;
        ready_ok = 1'b1;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (in_ready) ready_ok = 1'b0;
        end while (!out_valid && n < 100);
        chk("latency", 64'(n), 64'd32);
        chk("in_ready_low_busy", 64'(ready_ok), 64'd1);
        chk("product", product, exp_p);
        chk("hi_nonzero", 64'(hi_nonzero), 64'(exp_p[63:32] != 0));
        chk("err", 64'(err), 64'(model_err(d, r)));
        if (hold > 0) begin
            stable_ok = 1'b1;
            repeat (hold) begin
                in_valid = $urandom_range(0, 1);
                quotient = $urandom;
                divisor  = $urandom;
                residue  = $urandom;
                @(negedge clk);
                if (product !== exp_p || !out_valid || in_ready) stable_ok = 1'b0;
            end
            in_valid = 1'b0;
            chk("backpressure_stable", 64'(stable_ok), 64'd1);
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("idle_after_handoff", {62'd0, in_ready, out_valid}, 64'd2);
        chk("err_cleared", 64'(err), 64'd0);
        if (hold > 0) out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        time t_first;
        bit quiet;
        logic [31:0] q, d, r;

        // Reset state
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_product", product, 64'd0);
        chk("rst_hi_nonzero", 64'(hi_nonzero), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op(32'd1, 32'd4532, 32'd2309, 0);
        run_op(32'd37, 32'd123, 32'd86, 0);
        t_first = t_acc;
        run_op(32'd1, 32'd274, 32'd179, 0);
        chk("throughput", 64'(t_acc - t_first), 64'(34 * 10));
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(32'd12345, 32'd678, 32'd9, 10);
        run_op(32'd7, 32'd274, 32'd300, 0);
        run_op(32'd99, 32'd0, 32'd5, 0);
        run_op(32'd0, 32'd10, 32'd3, 0);

        // Reset during BUSY
        @(negedge clk);
        quotient = 32'hDEAD_BEEF;
        divisor  = 32'h1234_5678;
        residue  = 32'h5;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_product", product, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || !in_ready) quiet = 1'b0;
        end
        chk("abort_no_result", 64'(quiet), 64'd1);
        run_op(32'd5, 32'd6, 32'd2, 0);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            q = $urandom;
            d = $urandom;
            r = $urandom;
            case (i % 4)
                0: begin q = q & 32'hFFFF; d = d & 32'hFFFF; end
                1: if (d != 0) r = r % d;
                2: d = (d & 32'h1) ? 32'hFFFF_FFFF : 32'h8000_0001;
                default: ;
            endcase
            run_op(q, d, r, (i % 3 == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
